// File: rtl/ff_conv_bank.sv
// Purpose: WIDTH-bit bank of flip-flops that behave as D, T, JK or SR per a shared registered mode.
// Latency: 1 cycle; q, mode, sr_err and chg_cnt are all registered, no combinational input->output path.
// Backpressure: none; en=0 freezes q/sr_err/chg_cnt while mode_ld still updates the mode register.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   en            update enable for q, sr_err, chg_cnt
//   mode_ld       load mode_in (0=D 1=T 2=JK 3=SR) into the mode register
//   a, b          per-bit D/T/J/S and K/R inputs (b ignored in D and T)
//   q             flip-flop outputs
//   mode          current registered mode
//   sr_err        sticky flag: S=R=1 seen on an enabled SR edge
//   chg_cnt       saturating count of enabled edges on which q changed
//   clr           synchronous clear, present only when FF_CONV_SYNC_CLR_EN is defined
//
// Optional feature macro: FF_CONV_SYNC_CLR_EN

module ff_conv_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter logic [1:0]       MODE_INIT = 2'd2,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode_ld,
    input  logic [1:0]       mode_in,
`ifdef FF_CONV_SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       mode,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0] MODE_D  = 2'd0;
    localparam logic [1:0] MODE_T  = 2'd1;
    localparam logic [1:0] MODE_JK = 2'd2;
    localparam logic [1:0] MODE_SR = 2'd3;

    logic [WIDTH-1:0] q_nxt;
    logic             sr_ill;
    logic             q_chg;
    logic             clr_i;

`ifdef FF_CONV_SYNC_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    // Next state is computed from the mode held before the edge, so a
    // simultaneous mode_ld only takes effect on the following edge.
    always_comb begin
        q_nxt  = q;
        sr_ill = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_D:  q_nxt[i] = a[i];
                MODE_T:  q_nxt[i] = q[i] ^ a[i];
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b01:   q_nxt[i] = 1'b0;
                        2'b10:   q_nxt[i] = 1'b1;
                        2'b11:   q_nxt[i] = ~q[i];
                        default: q_nxt[i] = q[i];
                    endcase
                end
                default: begin
                    // SR: an illegal S=R=1 bit holds its value and flags the error
                    case ({a[i], b[i]})
                        2'b01:   q_nxt[i] = 1'b0;
                        2'b10:   q_nxt[i] = 1'b1;
                        2'b11: begin
                            q_nxt[i] = q[i];
                            sr_ill   = 1'b1;
                        end
                        default: q_nxt[i] = q[i];
                    endcase
                end
            endcase
        end
    end

    assign q_chg = (q_nxt != q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= RST_VAL;
            mode    <= MODE_INIT;
            sr_err  <= 1'b0;
            chg_cnt <= '0;
        end else begin
            if (mode_ld) begin
                mode <= mode_in;
            end
            if (clr_i) begin
                q       <= RST_VAL;
                sr_err  <= 1'b0;
                chg_cnt <= '0;
            end else if (en) begin
                q <= q_nxt;
                if (sr_ill) begin
                    sr_err <= 1'b1;
                end
                // Saturate at all-ones rather than wrap
                if (q_chg && (chg_cnt != '1)) begin
                    chg_cnt <= chg_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
